quant_zigzag: RTL and testbench
===============================

QUANT_ZIGZAG -- requirements
Module: quant_zigzag

Interface
REQ-001 aclk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-002 areset  input  1  asynchronous, active-high reset.
REQ-003 in_data  input  256  one 8-coefficient row of a 2D-DCT block; bits [32c+31:32c] = column c; signed two's-complement integer.
REQ-004 in_valid  input  1  in_data holds a valid row.
REQ-005 in_ready  output  1  block can accept a row.
REQ-006 out_data  output  16  quantized coefficient, signed, saturated.
REQ-007 out_index  output  6  zigzag position k (0..63) of out_data.
REQ-008 out_last  output  1  asserted with k=63.
REQ-009 out_valid  output  1  out_data, out_index and out_last are valid.
REQ-010 out_ready  input  1  downstream consumer accepts the output.

Function
REQ-011 An input beat SHALL transfer on a rising edge where in_valid&in_ready; rows arrive in order r=0..7.
REQ-012 An output beat SHALL transfer on a rising edge where out_valid&out_ready.
REQ-013 FSM states: IDLE (row count 0, in_ready=1), FILL (rows 1..7 received, in_ready=1), DRAIN (in_ready=0).
REQ-014 IDLE->FILL on the first row beat; FILL->DRAIN on the 8th row beat; DRAIN->IDLE on the output beat with out_last=1.
REQ-015 Rows SHALL be stored in a 64x32 buffer at index 8r+c.
REQ-016 out_valid SHALL rise the cycle after the 8th row beat; out_index SHALL be 0 for that beat.
REQ-017 In DRAIN, k SHALL increment by 1 per output beat; output k SHALL come from buffer index ZZ[k] (standard JPEG zigzag: 0,1,8,16,9,2,3,10,...,63).
REQ-018 Quantization: p = coef * RECIP[ZZ[k]] as a 48-bit signed product, RECIP[i] = round(65536/QLUMA[i]); result = (p + 32768) >>> 16 (arithmetic shift).
REQ-019 Result SHALL saturate to [-32768, 32767] before driving out_data.
REQ-020 out_data/out_index/out_last SHALL be registered and held stable while out_valid&!out_ready.
REQ-021 Throughput SHALL be one coefficient per cycle with out_ready held high; one block = 8 input cycles + 64 output cycles.
REQ-022 The first row of the next block SHALL be accepted no earlier than the cycle after the out_last beat; input beats during DRAIN are not accepted.
REQ-023 out_valid SHALL be 0 in IDLE and FILL.

Reset
REQ-024 While areset=1: state=IDLE, row count=0, k=0, out_valid=0, out_last=0, out_data=0, out_index=0, in_ready=1.
REQ-025 areset asserted at any time SHALL discard the partial or draining block; buffer contents need no reset.
REQ-026 areset release SHALL be synchronized to aclk before deassertion reaches the FSM.

Structure
REQ-027 A shared package SHALL hold the ZZ[64] table, the QLUMA[64] table (standard JPEG luminance table, quality 50), the RECIP[64] table, and the widths COEF_W=32, OUT_W=16, RECIP_FRAC=16.
REQ-028 One sub-module, quant_mul_sat (multiply, round, saturate; combinational), SHALL be instantiated once.

Verification
REQ-029 Reset: assert areset mid-FILL -> out_valid=0, in_ready=1; next 8 rows form a fresh block.
REQ-030 DC only: (0,0)=160, others 0 -> beat k=0 out_data=10; beats 1..63 = 0; out_last only on beat 64; out_valid rises 1 cycle after row 7.
REQ-031 Order: coef(r,c)=QLUMA[8r+c]*(8r+c) -> beat k out_data=ZZ[k] (k=2 -> 8, k=3 -> 16, k=63 -> 63).
REQ-032 Rounding/saturation: (0,0)=-24 -> -1; (0,0)=0x7FFFFFFF -> 32767; (0,0)=0x80000000 -> -32768.
REQ-033 Backpressure: out_ready random 50% -> 64 beats in order, outputs stable while stalled, in_ready=0 until the cycle after out_last fires.
REQ-034 Back-to-back: two blocks with in_valid held high -> second block's row 0 accepted the cycle after first out_last beat; 144 cycles total with out_ready=1.

Source files
------------

// File: rtl/quant_zigzag_pkg.sv
// Shared constants for the quantize/zigzag block: scan order, JPEG luma table (q=50),
// fixed-point reciprocals and datapath widths.
package quant_zigzag_pkg;

  localparam int unsigned COEF_W     = 32;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned RECIP_FRAC = 16;
  localparam int unsigned RECIP_W    = RECIP_FRAC + 1;
  localparam int unsigned PROD_W     = 48;
  localparam int unsigned ROW_W      = 8 * COEF_W;

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  // Raster index of the coefficient emitted at zigzag position k
  localparam int unsigned ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam int unsigned QLUMA [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  // round(65536 / QLUMA[i]), raster order
  localparam int unsigned RECIP [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

endpackage

// File: rtl/quant_zigzag_if.sv
// Row-input and coefficient-output streams of quant_zigzag.
interface quant_zigzag_if;
  import quant_zigzag_pkg::*;

  logic [ROW_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic [5:0]       out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid
  );

endinterface

// File: rtl/quant_mul_sat.sv
// Combinational quantizer: coef * recip, round half up at RECIP_FRAC, saturate to OUT_W.
module quant_mul_sat
  import quant_zigzag_pkg::*;
(
  input  logic [COEF_W-1:0]  coef,
  input  logic [RECIP_W-1:0] recip,
  output logic [OUT_W-1:0]   result
);

  localparam logic signed [PROD_W-1:0] Half    = PROD_W'(64'd1 << (RECIP_FRAC - 1));
  localparam logic signed [PROD_W-1:0] MaxOut  = PROD_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [PROD_W-1:0] MinOut  = -MaxOut - PROD_W'(1);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;

  always_comb begin
    prod    = $signed({{(PROD_W - COEF_W){coef[COEF_W-1]}}, coef})
            * $signed({{(PROD_W - RECIP_W){1'b0}}, recip});
    rounded = prod + Half;
    shifted = rounded >>> RECIP_FRAC;
    if (shifted > MaxOut) begin
      result = OUT_W'(MaxOut);
    end else if (shifted < MinOut) begin
      result = OUT_W'(MinOut);
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/quant_zigzag.sv
// Collects an 8x8 block row by row, then streams it out in zigzag order, quantized
// against the JPEG luma table, one coefficient per accepted output beat.
module quant_zigzag
  import quant_zigzag_pkg::*;
(
  input logic           aclk,
  input logic           areset,
  quant_zigzag_if.slave bus
);

  // Assert asynchronously, release two edges after areset drops
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic             out_valid_q;
  logic             out_last_q;
  logic [OUT_W-1:0] out_data_q;
  logic [5:0]       out_index_q;

  logic               in_fire, out_fire;
  logic               load_first, load_next;
  logic [5:0]         sel_k, buf_idx;
  logic [RECIP_W-1:0] recip_sel;
  logic [OUT_W-1:0]   q_res;
  logic [COEF_W-1:0]  buf_q [64];

  assign bus.in_ready  = (state_q != StDrain);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge aclk) begin
    if (in_fire) begin
      for (int c = 0; c < 8; c++) begin
        buf_q[{row_q, 3'(c)}] <= bus.in_data[c*COEF_W +: COEF_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    load_first = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          state_d = StFill;
          row_d   = 3'd1;
        end
      end
      StFill: begin
        if (in_fire) begin
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) begin
            state_d    = StDrain;
            load_first = 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_fire && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ZZ[0] is raster 0, already stored, so k=0 can be fetched on the 8th row beat
  assign load_next = (state_q == StDrain) && out_fire && !out_last_q;
  assign sel_k     = load_first ? 6'd0 : out_index_q + 6'd1;
  assign buf_idx   = 6'(ZZ[sel_k]);
  assign recip_sel = RECIP_W'(RECIP[buf_idx]);

  quant_mul_sat u_mul (
    .coef   (buf_q[buf_idx]),
    .recip  (recip_sel),
    .result (q_res)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= 6'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (load_first || load_next) begin
        out_valid_q <= 1'b1;
        out_data_q  <= q_res;
        out_index_q <= sel_k;
        out_last_q  <= (sel_k == 6'd63);
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quant_zigzag.sv
// Randomized bench for quant_zigzag against a zigzag/quantization reference model.
module tb_quant_zigzag;

  logic aclk = 1'b0;
  logic areset;

  quant_zigzag_if bus ();

  quant_zigzag dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  int q [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };
  int zz [64];

  logic [31:0] blk [64];
  logic [15:0] cap_data [64];
  logic [5:0]  cap_idx [64];
  logic        cap_last [64];
  int nbeats, cycles, first_valid_cyc, row0_cyc, row8_cyc;
  int early_valid, unstable, drain_ready;
  int ready_pct;
  bit hold_valid;

  // Zigzag order by walking anti-diagonals, alternating direction
  function automatic void build_zz();
    int k, lo, hi, r;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      for (int i = 0; i <= hi - lo; i++) begin
        r = (s % 2 == 1) ? lo + i : hi - i;
        zz[k] = 8 * r + (s - r);
        k++;
      end
    end
  endfunction

  function automatic logic [15:0] quant_ref(input logic [31:0] w, input int qv);
    longint c, r, v;
    c = longint'($signed(w));
    r = longint'((65536 + qv / 2) / qv);
    v = (c * r + 64'sd32768) >>> 16;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [31:0] rand_coef();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'(int'($urandom_range(4000)) - 2000);
      2: return 32'(int'($urandom_range(2000000)) - 1000000);
      default: return 32'd0;
    endcase
  endfunction

  // Drives one block and records every output beat plus protocol observations
  task automatic run_block();
    int row;
    bit stalled;
    logic [15:0] hd;
    logic [5:0] hx;
    logic hl;
    row = 0; stalled = 0; hd = '0; hx = '0; hl = 1'b0;
    nbeats = 0; cycles = 0; first_valid_cyc = -1; row0_cyc = -1; row8_cyc = -1;
    early_valid = 0; unstable = 0; drain_ready = 0;
    while (nbeats < 64 && cycles < 3000) begin
      bus.in_valid = (row < 8) || hold_valid;
      if (row < 8) begin
        for (int c = 0; c < 8; c++) bus.in_data[32*c +: 32] = blk[8*row + c];
      end else begin
        for (int c = 0; c < 8; c++) bus.in_data[32*c +: 32] = $urandom;
      end
      bus.out_ready = ($urandom_range(99) < ready_pct);
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cycles;
        if (row < 8) early_valid++;
        if (stalled && (bus.out_data !== hd || bus.out_index !== hx || bus.out_last !== hl))
          unstable++;
      end
      if (row == 8 && bus.in_ready) drain_ready++;
      stalled = bus.out_valid && !bus.out_ready;
      hd = bus.out_data; hx = bus.out_index; hl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        cap_data[nbeats] = bus.out_data;
        cap_idx[nbeats]  = bus.out_index;
        cap_last[nbeats] = bus.out_last;
        nbeats++;
      end
      if (row < 8 && bus.in_ready) begin
        if (row == 0) row0_cyc = cycles;
        if (row == 7) row8_cyc = cycles;
        row++;
      end
      @(posedge aclk); #1;
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.out_data !== 16'd0) begin fails++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
    tests++; if (bus.out_index !== 6'd0) begin fails++; $display("FAIL rst_out_index got %0d want 0", bus.out_index); end
    tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
    areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    // Three junk rows leave the block mid-fill
    for (int r = 0; r < 3; r++) begin
      bus.in_valid = 1'b1;
      for (int c = 0; c < 8; c++) bus.in_data[32*c +: 32] = $urandom | 32'h1;
      @(posedge aclk); #1;
    end
    bus.in_valid = 1'b0;
    areset = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midfill_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midfill_in_ready got %b want 1", bus.in_ready); end
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    for (int i = 0; i < 64; i++) blk[i] = rand_coef();
    ready_pct = 100; hold_valid = 0;
    run_block();
    tests++; if (nbeats !== 64) begin fails++; $display("FAIL fresh_beats got %0d want 64", nbeats); end
    tests++; if (cycles !== 72) begin fails++; $display("FAIL fresh_cycles got %0d want 72", cycles); end
    for (int k = 0; k < 64; k++) begin
      logic [15:0] e;
      e = quant_ref(blk[zz[k]], q[zz[k]]);
      tests++; if (cap_data[k] !== e) begin fails++; $display("FAIL fresh_data k=%0d got %h want %h", k, cap_data[k], e); end
    end
  endtask

  task automatic test_dc();
    for (int i = 0; i < 64; i++) blk[i] = 32'd0;
    blk[0] = 32'd160;
    ready_pct = 100; hold_valid = 0;
    run_block();
    tests++; if (nbeats !== 64) begin fails++; $display("FAIL dc_beats got %0d want 64", nbeats); end
    tests++; if (first_valid_cyc !== row8_cyc + 1) begin fails++; $display("FAIL dc_latency got %0d want %0d", first_valid_cyc, row8_cyc + 1); end
    tests++; if (early_valid !== 0) begin fails++; $display("FAIL dc_valid_in_fill got %0d want 0", early_valid); end
    tests++; if (cap_data[0] !== 16'd10) begin fails++; $display("FAIL dc_k0 got %0d want 10", $signed(cap_data[0])); end
    for (int k = 0; k < 64; k++) begin
      tests++; if (k > 0 && cap_data[k] !== 16'd0) begin fails++; $display("FAIL dc_ac k=%0d got %h want 0", k, cap_data[k]); end
      tests++; if (cap_idx[k] !== 6'(k)) begin fails++; $display("FAIL dc_index k=%0d got %0d want %0d", k, cap_idx[k], k); end
      tests++; if (cap_last[k] !== (k == 63)) begin fails++; $display("FAIL dc_last k=%0d got %b want %b", k, cap_last[k], k == 63); end
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL dc_idle_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_order();
    for (int i = 0; i < 64; i++) blk[i] = 32'(q[i] * i);
    ready_pct = 100; hold_valid = 0;
    run_block();
    tests++; if (nbeats !== 64) begin fails++; $display("FAIL order_beats got %0d want 64", nbeats); end
    for (int k = 0; k < 64; k++) begin
      tests++; if (cap_data[k] !== 16'(zz[k])) begin fails++; $display("FAIL order k=%0d got %0d want %0d", k, cap_data[k], zz[k]); end
    end
  endtask

  task automatic test_round_sat();
    logic [31:0] dc [3];
    logic [15:0] want [3];
    dc[0] = 32'hFFFF_FFE8; want[0] = 16'hFFFF;
    dc[1] = 32'h7FFF_FFFF; want[1] = 16'h7FFF;
    dc[2] = 32'h8000_0000; want[2] = 16'h8000;
    ready_pct = 100; hold_valid = 0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) blk[i] = rand_coef();
      blk[0] = dc[t];
      run_block();
      tests++; if (cap_data[0] !== want[t]) begin fails++; $display("FAIL round_sat_dc case=%0d got %h want %h", t, cap_data[0], want[t]); end
      for (int k = 1; k < 64; k++) begin
        logic [15:0] e;
        e = quant_ref(blk[zz[k]], q[zz[k]]);
        tests++; if (cap_data[k] !== e) begin fails++; $display("FAIL round_sat case=%0d k=%0d got %h want %h", t, k, cap_data[k], e); end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 64; i++) blk[i] = rand_coef();
    ready_pct = 50; hold_valid = 0;
    run_block();
    tests++; if (nbeats !== 64) begin fails++; $display("FAIL bp_beats got %0d want 64", nbeats); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    tests++; if (drain_ready !== 0) begin fails++; $display("FAIL bp_in_ready_drain got %0d want 0", drain_ready); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_after got %b want 1", bus.in_ready); end
    for (int k = 0; k < 64; k++) begin
      logic [15:0] e;
      e = quant_ref(blk[zz[k]], q[zz[k]]);
      tests++; if (cap_data[k] !== e) begin fails++; $display("FAIL bp_data k=%0d got %h want %h", k, cap_data[k], e); end
      tests++; if (cap_idx[k] !== 6'(k)) begin fails++; $display("FAIL bp_index k=%0d got %0d want %0d", k, cap_idx[k], k); end
      tests++; if (cap_last[k] !== (k == 63)) begin fails++; $display("FAIL bp_last k=%0d got %b want %b", k, cap_last[k], k == 63); end
    end
  endtask

  task automatic test_back_to_back();
    int total;
    ready_pct = 100; hold_valid = 1;
    total = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = rand_coef();
      run_block();
      total += cycles;
      tests++; if (row0_cyc !== 0) begin fails++; $display("FAIL b2b_row0 blk=%0d got %0d want 0", b, row0_cyc); end
      tests++; if (drain_ready !== 0) begin fails++; $display("FAIL b2b_in_ready_drain blk=%0d got %0d want 0", b, drain_ready); end
      for (int k = 0; k < 64; k++) begin
        logic [15:0] e;
        e = quant_ref(blk[zz[k]], q[zz[k]]);
        tests++; if (cap_data[k] !== e) begin fails++; $display("FAIL b2b_data blk=%0d k=%0d got %h want %h", b, k, cap_data[k], e); end
      end
    end
    hold_valid = 0;
    tests++; if (total !== 144) begin fails++; $display("FAIL b2b_cycles got %0d want 144", total); end
  endtask

  initial begin
    areset        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    hold_valid    = 0;
    ready_pct     = 100;
    build_zz();
    test_reset();
    test_dc();
    test_order();
    test_round_sat();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
